// File: rtl/scan_chain_loader.sv
// Configuration scan-chain loader: serialises config words onto the PE array
// scan chain and returns the bits that fall out of the chain as readback words.
module scan_chain_loader #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CHAIN_LEN  = 1024,
  parameter int unsigned CNT_WIDTH  = $clog2(CHAIN_LEN + 1),
  parameter int unsigned IDX_WIDTH  = $clog2(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [WORD_WIDTH-1:0] rb_word,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic                  scan_en,
  output logic                  scan_in,
  input  logic                  scan_out
);

  localparam int unsigned NB_WIDTH = $clog2(WORD_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_RB,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [WORD_WIDTH-1:0] tx_q;
  logic [WORD_WIDTH-1:0] rb_q;
  logic [IDX_WIDTH-1:0]  bit_idx_q;
  logic [NB_WIDTH-1:0]   nbits_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cfg_ready_q;
  logic                  rb_valid_q;
  logic                  scan_en_q;
  logic                  scan_in_q;

  logic [NB_WIDTH-1:0]   nbits_d;
  logic [IDX_WIDTH-1:0]  bit_idx_d;
  logic                  last_bit;

  // Last word of a load may be shorter than a full word.
  assign nbits_d   = (32'(remaining_q) >= WORD_WIDTH) ? NB_WIDTH'(WORD_WIDTH)
                                                      : NB_WIDTH'(remaining_q);
  assign bit_idx_d = bit_idx_q + IDX_WIDTH'(1);
  assign last_bit  = ((NB_WIDTH'(bit_idx_q) + NB_WIDTH'(1)) == nbits_q);

  // FSM with outputs registered alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      tx_q        <= '0;
      rb_q        <= '0;
      bit_idx_q   <= '0;
      nbits_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      rb_valid_q  <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            remaining_q <= CNT_WIDTH'(CHAIN_LEN);
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            tx_q        <= cfg_word;
            rb_q        <= '0;
            bit_idx_q   <= '0;
            nbits_q     <= nbits_d;
            state_q     <= S_SHIFT;
            cfg_ready_q <= 1'b0;
            scan_en_q   <= 1'b1;
            scan_in_q   <= cfg_word[0];
          end
        end
        S_SHIFT: begin
          // Capture the chain's pre-edge output while pushing the next bit in.
          rb_q[bit_idx_q] <= scan_out;
          bit_idx_q       <= bit_idx_d;
          remaining_q     <= remaining_q - CNT_WIDTH'(1);
          if (last_bit) begin
            state_q    <= S_RB;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            rb_valid_q <= 1'b1;
          end else begin
            scan_in_q <= tx_q[bit_idx_d];
          end
        end
        S_RB: begin
          if (rb_ready) begin
            rb_valid_q <= 1'b0;
            if (remaining_q == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_LOAD;
              cfg_ready_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = cfg_ready_q;
  assign rb_word   = rb_q;
  assign rb_valid  = rb_valid_q;
  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench: a 70-bit and a 64-bit chain model driven by two loader instances.
module tb_scan_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- DUT A: CHAIN_LEN = 70 ----------------
  logic        a_reset, a_start, a_busy, a_done, a_cfg_valid, a_cfg_ready;
  logic        a_rb_valid, a_rb_ready, a_scan_en, a_scan_in, a_scan_out;
  logic [31:0] a_cfg_word, a_rb_word;
  logic        a_pre;
  logic [69:0] chain_a;

  scan_chain_loader #(.WORD_WIDTH(32), .CHAIN_LEN(70)) u_a (
    .clk(clk), .reset(a_reset), .start(a_start), .busy(a_busy), .done(a_done),
    .cfg_word(a_cfg_word), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
    .rb_word(a_rb_word), .rb_valid(a_rb_valid), .rb_ready(a_rb_ready),
    .scan_en(a_scan_en), .scan_in(a_scan_in), .scan_out(a_scan_out)
  );

  // ---------------- DUT B: CHAIN_LEN = 64 ----------------
  logic        b_reset, b_start, b_busy, b_done, b_cfg_valid, b_cfg_ready;
  logic        b_rb_valid, b_rb_ready, b_scan_en, b_scan_in, b_scan_out;
  logic [31:0] b_cfg_word, b_rb_word;
  logic        b_pre;
  logic [63:0] chain_b;

  scan_chain_loader #(.WORD_WIDTH(32), .CHAIN_LEN(64)) u_b (
    .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
    .cfg_word(b_cfg_word), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
    .rb_word(b_rb_word), .rb_valid(b_rb_valid), .rb_ready(b_rb_ready),
    .scan_en(b_scan_en), .scan_in(b_scan_in), .scan_out(b_scan_out)
  );

  // Stream bit i ends up in chain flop N-1-i after a full load.
  function automatic logic [69:0] rev70(input logic [69:0] s);
    logic [69:0] r;
    for (int i = 0; i < 70; i++) r[69-i] = s[i];
    return r;
  endfunction

  function automatic logic [63:0] rev64(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = s[i];
    return r;
  endfunction

  localparam logic [69:0] PRE_A   = {6'h15, 32'h9ABCDEF0, 32'h12345678};
  localparam logic [69:0] LOAD_A  = {6'h2D, 32'h0F0F0F0F, 32'hA5A5A5A5};
  localparam logic [63:0] PRE_B   = {32'hDEADBEEF, 32'hCAFEF00D};
  localparam logic [63:0] LOAD_B  = {32'h89ABCDEF, 32'h01234567};

  logic [69:0] chain_a_exp;
  logic [63:0] chain_b_exp;
  assign chain_a_exp = rev70(LOAD_A);
  assign chain_b_exp = rev64(LOAD_B);

  // Chain models: scan_in enters flop 0, scan_out is the last flop.
  always @(posedge clk) begin
    if (a_pre) chain_a <= rev70(PRE_A);
    else if (a_scan_en) chain_a <= {chain_a[68:0], a_scan_in};
  end
  assign a_scan_out = chain_a[69];

  always @(posedge clk) begin
    if (b_pre) chain_b <= rev64(PRE_B);
    else if (b_scan_en) chain_b <= {chain_b[62:0], b_scan_in};
  end
  assign b_scan_out = chain_b[63];

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Results of the most recent run_load.
  logic [31:0] rb_got [4];
  int nwords, ndone, nbusy, en_tot, nruns;
  int runs [4];

  // One full load on DUT A, sampling every cycle at the falling edge.
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int cfg_stall, input int rb_stall, input bit poke_start);
    logic [31:0] w [3];
    logic [31:0] held;
    int wi, stall, hold, run;
    w[0] = w0; w[1] = w1; w[2] = w2;
    wi = 0; stall = cfg_stall; hold = 0; run = 0; held = '0;
    nwords = 0; ndone = 0; nbusy = 0; en_tot = 0; nruns = 0;
    for (int i = 0; i < 4; i++) begin rb_got[i] = '0; runs[i] = 0; end
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (a_busy) nbusy++;
      if (a_scan_en) begin
        en_tot++; run++;
      end else if (run > 0) begin
        if (nruns < 4) runs[nruns] = run;
        nruns++; run = 0;
      end
      if (a_done) ndone++;
      a_cfg_valid = 1'b0; a_rb_ready = 1'b0; a_start = 1'b0;
      if (poke_start && (cyc == 5 || cyc == 40)) a_start = 1'b1;
      if (a_cfg_ready && wi < 3) begin
        if (wi == 1 && stall > 0) begin
          stall--;
          chk("cfg_stall_scan_en", 70'(a_scan_en), 70'(0));
        end else begin
          a_cfg_valid = 1'b1; a_cfg_word = w[wi]; wi++;
        end
      end
      if (a_rb_valid) begin
        if (hold == 0) held = a_rb_word;
        else chk("rb_stall_stable", 70'(a_rb_word), 70'(held));
        if (hold < rb_stall) hold++;
        else begin
          a_rb_ready = 1'b1;
          if (nwords < 4) rb_got[nwords] = a_rb_word;
          nwords++; hold = 0;
        end
      end
      if (a_done) begin
        if (poke_start) a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        break;
      end
      @(negedge clk);
    end
    a_cfg_valid = 1'b0; a_rb_ready = 1'b0;
    chk("done_count", 70'(ndone), 70'(1));
    chk("busy_after_done", 70'(a_busy), 70'(0));
  endtask

  task automatic chk_rb(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2);
    chk({tag, "_nwords"}, 70'(nwords), 70'(3));
    chk({tag, "_rb0"}, 70'(rb_got[0]), 70'(e0));
    chk({tag, "_rb1"}, 70'(rb_got[1]), 70'(e1));
    chk({tag, "_rb2"}, 70'(rb_got[2]), 70'(e2));
    chk({tag, "_chain"}, chain_a, chain_a_exp);
  endtask

  int en, bwi, bn, bdone, ben;
  logic [31:0] brb [2];

  initial begin
    a_reset = 1'b0; a_start = 1'b0; a_cfg_word = '0; a_cfg_valid = 1'b0; a_rb_ready = 1'b0;
    b_reset = 1'b0; b_start = 1'b0; b_cfg_word = '0; b_cfg_valid = 1'b0; b_rb_ready = 1'b0;
    a_pre = 1'b1; b_pre = 1'b1;
    repeat (3) @(negedge clk);
    a_pre = 1'b0; b_pre = 1'b0;

    // Reset state
    chk("rst_busy", 70'(a_busy), 70'(0));
    chk("rst_done", 70'(a_done), 70'(0));
    chk("rst_cfg_ready", 70'(a_cfg_ready), 70'(0));
    chk("rst_rb_valid", 70'(a_rb_valid), 70'(0));
    chk("rst_scan_en", 70'(a_scan_en), 70'(0));
    chk("rst_scan_in", 70'(a_scan_in), 70'(0));
    chk("rst_rb_word", 70'(a_rb_word), 70'(0));
    a_reset = 1'b1; b_reset = 1'b1;

    // Pass 1: readback shows the preloaded pattern
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000002D, 0, 0, 1'b0);
    chk_rb("p1", 32'h12345678, 32'h9ABCDEF0, 32'h00000015);
    chk("p1_busy_cycles", 70'(nbusy), 70'(77));
    chk("p1_nruns", 70'(nruns), 70'(3));
    chk("p1_run0", 70'(runs[0]), 70'(32));
    chk("p1_run1", 70'(runs[1]), 70'(32));
    chk("p1_run2", 70'(runs[2]), 70'(6));

    // Pass 2: readback returns what pass 1 wrote
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000002D, 0, 0, 1'b0);
    chk_rb("p2", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000002D);

    // Pass 3: cfg stall before word 1; high bits of last word discarded
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFFED, 5, 0, 1'b0);
    chk_rb("p3", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000002D);
    chk("p3_busy_cycles", 70'(nbusy), 70'(82));
    chk("p3_run1", 70'(runs[1]), 70'(32));

    // Pass 4: rb_ready held low 4 cycles at each RB
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFFED, 0, 4, 1'b0);
    chk_rb("p4", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000002D);
    chk("p4_shift_cycles", 70'(en_tot), 70'(70));
    chk("p4_busy_cycles", 70'(nbusy), 70'(89));

    // Reset around bit 40 of a load
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    a_cfg_valid = 1'b1; a_cfg_word = 32'h3C3C3C3C; a_rb_ready = 1'b1;
    en = 0;
    for (int c = 0; c < 200; c++) begin
      if (a_scan_en) en++;
      if (en == 40) break;
      @(negedge clk);
    end
    chk("mid_reached_bit40", 70'(en), 70'(40));
    a_reset = 1'b0;
    @(negedge clk);
    a_cfg_valid = 1'b0; a_rb_ready = 1'b0;
    chk("mid_rst_busy", 70'(a_busy), 70'(0));
    chk("mid_rst_cfg_ready", 70'(a_cfg_ready), 70'(0));
    chk("mid_rst_rb_valid", 70'(a_rb_valid), 70'(0));
    chk("mid_rst_scan_en", 70'(a_scan_en), 70'(0));
    chk("mid_rst_scan_in", 70'(a_scan_in), 70'(0));
    chk("mid_rst_rb_word", 70'(a_rb_word), 70'(0));
    a_reset = 1'b1;

    // Fresh load with start pulses while busy
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000002D, 0, 0, 1'b1);
    chk("p5_nwords", 70'(nwords), 70'(3));
    chk("p5_chain", chain_a, chain_a_exp);
    chk("p5_busy_cycles", 70'(nbusy), 70'(77));

    // DUT B: chain length an exact multiple of the word width
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    b_cfg_valid = 1'b1; b_rb_ready = 1'b1;
    bwi = 0; bn = 0; bdone = 0; ben = 0; brb[0] = '0; brb[1] = '0;
    for (int c = 0; c < 500; c++) begin
      if (b_scan_en) ben++;
      if (b_rb_valid) begin
        if (bn < 2) brb[bn] = b_rb_word;
        bn++;
      end
      if (b_cfg_ready) begin
        b_cfg_word = (bwi == 0) ? LOAD_B[31:0] : LOAD_B[63:32];
        bwi++;
      end
      if (b_done) begin bdone++; break; end
      @(negedge clk);
    end
    b_cfg_valid = 1'b0; b_rb_ready = 1'b0;
    chk("b_done", 70'(bdone), 70'(1));
    chk("b_nwords", 70'(bn), 70'(2));
    chk("b_shift_cycles", 70'(ben), 70'(64));
    chk("b_rb0", 70'(brb[0]), 70'(32'hCAFEF00D));
    chk("b_rb1", 70'(brb[1]), 70'(32'hDEADBEEF));
    chk("b_chain", 70'(chain_b), 70'(chain_b_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
